ip_mux_arbiter: RTL and testbench
=================================

// Module: ip_mux_arbiter
// PURPOSE
//  Frame-aware arbiter that drives the enable/select control of an S_COUNT-input ip_mux.
//  It watches per-input header-valid requests and the mux output handshakes.
//  It grants one input per frame (round-robin or fixed priority) and holds the grant until the last payload beat transfers.
//  It sits beside ip_mux in the IP transmit path, between the UDP/ICMP/raw-IP sources and the ip_eth_tx stage.
// PARAMETERS
//  S_COUNT         4   number of mux inputs (>=2)
//  ARB_TYPE_RR     1   1: round-robin starting after last grant; 0: fixed priority, lowest index wins
//  CL_S_COUNT      $clog2(S_COUNT)  select width (derived, do not override)
// PORTS
//  clk                        in   1           clock
//  rst                        in   1           reset, asynchronous, active-high
//  req                        in   S_COUNT     per-input s_ip_hdr_valid
//  m_ip_hdr_valid             in   1           mux output header valid
//  m_ip_hdr_ready             in   1           mux output header ready
//  m_ip_payload_axis_tvalid   in   1           mux output payload valid
//  m_ip_payload_axis_tready   in   1           mux output payload ready
//  m_ip_payload_axis_tlast    in   1           mux output payload last
//  enable                     out  1           to ip_mux enable
//  select                     out  CL_S_COUNT  to ip_mux select
//  grant                      out  S_COUNT     one-hot of the current grant; 0 when idle
//  busy                       out  1           a frame is granted and in flight
//  frame_count                out  16          completed frames, wraps at 0xFFFF->0
// BEHAVIOUR
//  - All outputs are registered. Reset values: enable=0, select=0, grant=0, busy=0, frame_count=0, rr pointer=S_COUNT-1.
//  - Let hdr_xfer  = m_ip_hdr_valid & m_ip_hdr_ready.
//  - Let last_xfer = m_ip_payload_axis_tvalid & m_ip_payload_axis_tready & m_ip_payload_axis_tlast.
//  - FSM states: IDLE, HDR, PAYLOAD.
//  - IDLE: if |req, pick the winner W.
//      RR: first set bit scanning upward from ptr+1, with modulo wrap.
//      Fixed priority: lowest set index.
//    On the next edge: select=W, grant=1<<W, enable=1, busy=1, go to HDR. Latency is 1 cycle from req to enable.
//  - HDR: enable stays 1 and select stays stable.
//    On hdr_xfer: enable<=0 so the mux cannot start a second frame, ptr<=W, go to PAYLOAD.
//    If hdr_xfer and last_xfer occur in the same cycle (zero-length payload already done), go directly to IDLE and count the frame.
//  - PAYLOAD: enable=0, select and grant are held. On last_xfer: grant<=0, busy<=0, frame_count++, go to IDLE.
//  - Back-to-back frames: after returning to IDLE, re-arbitration takes 1 cycle. One bubble cycle between frames is required and accepted.
//  - A req dropping while in HDR is a protocol violation. The grant is held anyway; no recovery.
//  - Requests arriving during HDR or PAYLOAD are ignored until IDLE.
//  - last_xfer seen in IDLE or HDR without a prior hdr_xfer is ignored.
//  - Async rst mid-frame: return to IDLE immediately. The mux and sources must be reset on the same rst.
//  - Non-power-of-2 S_COUNT: select never exceeds S_COUNT-1. The RR wrap uses modulo S_COUNT.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, HDR=2'd1, PAYLOAD=2'd2).
//  - One sub-module, arb_rr_pick: combinational S_COUNT-wide round-robin/priority encoder.
//    Inputs: req, ptr, ARB_TYPE_RR. Outputs: valid, index, one-hot.
//  - The top level holds the FSM, the pointer and the frame counter.
//  - Testbench pairs this block with ip_mux (S_COUNT=4, 64-bit data) so that the select/enable wiring is exercised end to end.
// TESTING
//  1. Reset: rst=1 with req=4'b1111 -> enable=0, grant=0, frame_count=0. After release, enable=1 and select=0 one cycle later.
//  2. RR fairness: req=4'b1111 held for 8 frames of 3 beats each -> select sequence 0,1,2,3,0,1,2,3; frame_count=8.
//  3. Fixed priority (ARB_TYPE_RR=0): req=4'b1010 for 3 frames -> select=1 every time; input 3 starved.
//  4. Hold through backpressure: grant=4'b0100 with m_ip_payload_axis_tready toggling and req[0] rising mid-frame.
//     -> grant unchanged until tlast; next grant=4'b0001 after a 1-cycle bubble.
//  5. Same-cycle hdr/last: single-beat frame where hdr_xfer and last_xfer coincide on input 2 -> IDLE the next cycle; frame_count+1.
//  6. Reset mid-PAYLOAD: assert rst after 2 of 5 beats -> busy=0 and grant=0 asynchronously; RR pointer back to S_COUNT-1.

Source files
------------

// File: rtl/ip_mux_arbiter_pkg.sv
// Shared types for the ip_mux frame arbiter.
// Latency: n/a. Backpressure: n/a.
package ip_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ip_mux_arbiter_arb_rr_pick.sv
// Combinational round-robin / fixed-priority pick over S_COUNT requests.
// Latency: 0 cycles. Backpressure: none, pure function of req and ptr.
module arb_rr_pick #(
    parameter int S_COUNT     = 4,
    parameter int ARB_TYPE_RR = 1,
    parameter int CL_S_COUNT  = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]    req,
    input  logic [CL_S_COUNT-1:0] ptr,
    output logic                  valid,
    output logic [CL_S_COUNT-1:0] index,
    output logic [S_COUNT-1:0]    onehot
);

    logic [S_COUNT-1:0] upper;
    logic [S_COUNT-1:0] scan;

    always_comb begin
        upper = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            upper[i] = (ARB_TYPE_RR != 0) && (i > int'(ptr)) && req[i];
        end
        // nothing above the pointer means the search wraps to the bottom
        scan  = (|upper) ? upper : req;
        valid = |req;
        index = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (scan[i]) begin
                index = CL_S_COUNT'(i);
            end
        end
        onehot = valid ? (S_COUNT'(1) << index) : '0;
    end

endmodule

// File: rtl/ip_mux_arbiter.sv
// Frame-aware arbiter driving ip_mux enable/select; holds a grant until tlast transfers.
// Latency: 1 cycle req->enable, 1 idle bubble between frames. Backpressure: follows mux handshakes only.
module ip_mux_arbiter
    import ip_mux_arbiter_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int ARB_TYPE_RR = 1,
    parameter int CL_S_COUNT  = $clog2(S_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S_COUNT-1:0]    req,
    input  logic                  m_ip_hdr_valid,
    input  logic                  m_ip_hdr_ready,
    input  logic                  m_ip_payload_axis_tvalid,
    input  logic                  m_ip_payload_axis_tready,
    input  logic                  m_ip_payload_axis_tlast,
    output logic                  enable,
    output logic [CL_S_COUNT-1:0] select,
    output logic [S_COUNT-1:0]    grant,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    arb_state_t            state_q, state_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;
    logic [CL_S_COUNT-1:0] select_q, select_d;
    logic [CL_S_COUNT-1:0] ptr_q, ptr_d;
    logic [S_COUNT-1:0]    grant_q, grant_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic                  pick_valid;
    logic [CL_S_COUNT-1:0] pick_index;
    logic [S_COUNT-1:0]    pick_onehot;
    logic                  hdr_xfer;
    logic                  last_xfer;

    assign hdr_xfer  = m_ip_hdr_valid & m_ip_hdr_ready;
    assign last_xfer = m_ip_payload_axis_tvalid & m_ip_payload_axis_tready & m_ip_payload_axis_tlast;

    arb_rr_pick #(
        .S_COUNT    (S_COUNT),
        .ARB_TYPE_RR(ARB_TYPE_RR),
        .CL_S_COUNT (CL_S_COUNT)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_index),
        .onehot(pick_onehot)
    );

    always_comb begin
        state_d       = state_q;
        enable_d      = enable_q;
        busy_d        = busy_q;
        select_d      = select_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    select_d = pick_index;
                    grant_d  = pick_onehot;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_xfer) begin
                    // drop enable so the mux cannot accept a second header
                    enable_d = 1'b0;
                    ptr_d    = select_q;
                    if (last_xfer) begin
                        grant_d       = '0;
                        busy_d        = 1'b0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (last_xfer) begin
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
            select_q      <= '0;
            ptr_q         <= CL_S_COUNT'(S_COUNT - 1);
            grant_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            busy_q        <= busy_d;
            select_q      <= select_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign enable      = enable_q;
    assign busy        = busy_q;
    assign select      = select_q;
    assign grant       = grant_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ip_mux_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one stimulus stream;
// grants are predicted from request vectors and checked by an independent monitor.
`timescale 1ns/1ps
module tb_ip_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       hv = 1'b0, hr = 1'b0, tv = 1'b0, tr = 1'b0, tl = 1'b0;

    logic       en_rr, en_fp, busy_rr, busy_fp;
    logic [1:0] sel_rr, sel_fp;
    logic [3:0] g_rr, g_fp;
    logic [15:0] fc_rr, fc_fp;

    always #5 clk = ~clk;

    ip_mux_arbiter #(.S_COUNT(4), .ARB_TYPE_RR(1)) u_rr (
        .clk(clk), .rst(rst), .req(req),
        .m_ip_hdr_valid(hv), .m_ip_hdr_ready(hr),
        .m_ip_payload_axis_tvalid(tv), .m_ip_payload_axis_tready(tr), .m_ip_payload_axis_tlast(tl),
        .enable(en_rr), .select(sel_rr), .grant(g_rr), .busy(busy_rr), .frame_count(fc_rr)
    );

    ip_mux_arbiter #(.S_COUNT(4), .ARB_TYPE_RR(0)) u_fp (
        .clk(clk), .rst(rst), .req(req),
        .m_ip_hdr_valid(hv), .m_ip_hdr_ready(hr),
        .m_ip_payload_axis_tvalid(tv), .m_ip_payload_axis_tready(tr), .m_ip_payload_axis_tlast(tl),
        .enable(en_fp), .select(sel_fp), .grant(g_fp), .busy(busy_fp), .frame_count(fc_fp)
    );

    typedef struct {
        int sel_rr;
        int sel_fp;
        int cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         model_ptr = 3;
    int         pending_win = 0;
    int         done_cnt = 0;
    bit         gap_pending = 0;
    bit         use_force = 0;
    logic [3:0] force_req = 4'b1111;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // round-robin: first requester after the last winner, wrapping modulo 4
    function automatic int rr_win(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int fp_win(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic push_req(input logic [3:0] r);
        exp_t e;
        req         = r;
        e.sel_rr    = rr_win(r, model_ptr);
        e.sel_fp    = fp_win(r);
        e.cnt       = done_cnt;
        pending_win = e.sel_rr;
        exp_q.push_back(e);
    endtask

    task automatic finish_frame(input bit last_frame);
        done_cnt++;
        if (last_frame) begin
            req = 4'b0000;
        end else if (use_force) begin
            push_req(force_req);
        end else if ($urandom_range(0, 3) == 0) begin
            req         = 4'b0000;
            gap_pending = 1;
        end else begin
            push_req(4'($urandom_range(1, 15)));
        end
    endtask

    task automatic do_frame(input int beats, input bit zero_len, input bit last_frame);
        int n = 0;
        bit xf;
        while (!en_rr && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!en_rr) begin
            check("grant_timeout", 0, 1);
            return;
        end
        do begin
            hv = 1'b1;
            hr = ($urandom_range(0, 3) != 0);
            tv = 1'b0; tr = 1'b0; tl = 1'b0;
            if (hr) begin
                model_ptr = pending_win;
                if (zero_len) begin
                    tv = 1'b1; tr = 1'b1; tl = 1'b1;
                    finish_frame(last_frame);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // stray tlast before the header transfers must be ignored
                tv = 1'b1; tr = 1'b1; tl = 1'b1;
            end
            xf = hr;
            @(negedge clk);
        end while (!xf);
        hv = 1'b0; hr = 1'b0; tv = 1'b0; tr = 1'b0; tl = 1'b0;
        if (!zero_len) begin
            for (int b = 0; b < beats; b++) begin
                do begin
                    tv = 1'($urandom_range(0, 1));
                    tr = 1'($urandom_range(0, 1));
                    tl = (b == beats - 1);
                    if (!use_force && !(tv & tr & tl)) req = 4'($urandom_range(0, 15));
                    if (tv & tr & tl) finish_frame(last_frame);
                    xf = tv & tr;
                    @(negedge clk);
                end while (!xf);
            end
        end
        tv = 1'b0; tr = 1'b0; tl = 1'b0;
        check("bubble_busy", int'(busy_rr), 0);
        check("bubble_en", int'(en_rr), 0);
        check("bubble_grant_rr", int'(g_rr), 0);
        check("bubble_grant_fp", int'(g_fp), 0);
        if (gap_pending) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check("idle_no_en", int'(en_rr), 0);
            end
            push_req(4'($urandom_range(1, 15)));
            gap_pending = 0;
        end
    endtask

    // monitor: every rising enable is a new grant and consumes one prediction
    int   cur_rr = 0, cur_fp = 0;
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            en_prev = 1'b0;
        end else begin
            if (en_rr && !en_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sel_rr", int'(sel_rr), e.sel_rr);
                    check("grant_rr", int'(g_rr), 1 << e.sel_rr);
                    check("sel_fp", int'(sel_fp), e.sel_fp);
                    check("grant_fp", int'(g_fp), 1 << e.sel_fp);
                    check("en_fp", int'(en_fp), 1);
                    check("busy_rr", int'(busy_rr), 1);
                    check("busy_fp", int'(busy_fp), 1);
                    check("fc_rr", int'(fc_rr), e.cnt);
                    check("fc_fp", int'(fc_fp), e.cnt);
                    cur_rr = 1 << e.sel_rr;
                    cur_fp = 1 << e.sel_fp;
                end
            end else if (busy_rr) begin
                check("hold_rr", int'(g_rr), cur_rr);
                check("hold_fp", int'(g_fp), cur_fp);
            end
            en_prev = en_rr;
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_en", int'(en_rr), 0);
        check("rst_grant", int'(g_rr), 0);
        check("rst_busy", int'(busy_rr), 0);
        check("rst_fc", int'(fc_rr), 0);
        check("rst_sel", int'(sel_rr), 0);
        check("rst_grant_fp", int'(g_fp), 0);
        push_req(4'b1111);
        rst = 1'b0;
        @(negedge clk);
        check("release_en", int'(en_rr), 1);
        check("release_sel", int'(sel_rr), 0);

        use_force = 1;
        force_req = 4'b1111;
        for (int f = 0; f < 8; f++) do_frame(3, 0, 0);
        check("fc_after8", int'(fc_rr), 8);

        force_req = 4'b1010;
        for (int f = 0; f < 4; f++) do_frame(2, (f == 2), 0);

        force_req = 4'b0100;
        do_frame(1, 1, 0);
        check("zero_len_fc", int'(fc_rr), 13);

        use_force = 0;
        for (int f = 0; f < 30; f++) do_frame($urandom_range(1, 4), ($urandom_range(0, 5) == 0), 0);

        // reset in the middle of a 5-beat payload
        begin
            int n = 0;
            while (!en_rr && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("mid_rst_grant_seen", int'(en_rr), 1);
            hv = 1'b1; hr = 1'b1;
            @(negedge clk);
            hv = 1'b0; hr = 1'b0;
            repeat (2) begin
                tv = 1'b1; tr = 1'b1; tl = 1'b0;
                @(negedge clk);
            end
            tv = 1'b0; tr = 1'b0;
            check("mid_busy_pre", int'(busy_rr), 1);
            #2 rst = 1'b1;
            #1;
            check("mid_rst_busy", int'(busy_rr), 0);
            check("mid_rst_grant", int'(g_rr), 0);
            check("mid_rst_en", int'(en_rr), 0);
            check("mid_rst_fc", int'(fc_rr), 0);
            check("mid_rst_grant_fp", int'(g_fp), 0);
            exp_q.delete();
            done_cnt    = 0;
            model_ptr   = 3;
            gap_pending = 0;
            push_req(4'b1111);
            @(negedge clk);
            rst = 1'b0;
            do_frame(3, 0, 1);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_fc", int'(fc_rr), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
